// File: rtl/uart_frame_sched.sv
// uart_frame_sched: frame-level transmit controller in front of a byte-wide UART.
// Arbitrates two requesters round-robin, then serialises the granted request as
// SYNC, ID, payload (MSB byte first), 8-bit additive checksum of ID + payload.
// The UART's done/busy level paces the byte sequence.
//
// Ports:
//   sys_clk, sys_rst_l   clock and asynchronous active-low reset
//   req0/data0/ack0      requester 0: level request, payload, one-cycle latch ack
//   req1/data1/ack1      requester 1: level request, payload, one-cycle latch ack
//   xmitH, xmit_dataH    UART send strobe and byte (byte held until complete)
//   xmit_doneH           UART idle status (low while sending)
//   busy                 high from grant until the frame completes
//   frame_done           one-cycle pulse after the last byte completes
module uart_frame_sched #(
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter logic [7:0]  ID0           = 8'h01,
    parameter logic [7:0]  ID1           = 8'h02
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_l,
    input  logic                         req0,
    input  logic [8*PAYLOAD_BYTES-1:0]   data0,
    output logic                         ack0,
    input  logic                         req1,
    input  logic [8*PAYLOAD_BYTES-1:0]   data1,
    output logic                         ack1,
    output logic                         xmitH,
    output logic [7:0]                   xmit_dataH,
    input  logic                         xmit_doneH,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned DATA_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned IDX_W  = 4;
    // Index of the checksum byte (last byte of the frame).
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES + 2);
    // Index of the last payload byte; its completion loads the checksum.
    localparam logic [IDX_W-1:0] LAST_PAY_IDX = IDX_W'(PAYLOAD_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          chk_q, chk_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic [7:0]          id_q, id_d;
    logic [7:0]          xmit_data_q, xmit_data_d;
    logic                xmit_q, xmit_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                grant1_c;
    logic [7:0]          pay_byte_c;

    // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
    assign grant1_c   = req1 & (~req0 | ~last_grant_q);
    // Payload is shifted left as bytes go out, so the next byte is always on top.
    assign pay_byte_c = payload_q[DATA_W-1 -: 8];

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        chk_d        = chk_q;
        last_grant_d = last_grant_q;
        payload_d    = payload_q;
        id_d         = id_q;
        xmit_data_d  = xmit_data_q;
        xmit_d       = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((req0 | req1) & xmit_doneH) begin
                    state_d      = ST_SEND;
                    idx_d        = '0;
                    xmit_d       = 1'b1;
                    busy_d       = 1'b1;
                    xmit_data_d  = SYNC_BYTE;
                    last_grant_d = grant1_c;
                    if (grant1_c) begin
                        payload_d = data1;
                        id_d      = ID1;
                        chk_d     = ID1;
                        ack1_d    = 1'b1;
                    end else begin
                        payload_d = data0;
                        id_d      = ID0;
                        chk_d     = ID0;
                        ack0_d    = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (!xmit_doneH) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (xmit_doneH) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        idx_d        = '0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        idx_d   = idx_q + IDX_W'(1);
                        xmit_d  = 1'b1;
                        if (idx_q == '0) begin
                            xmit_data_d = id_q;
                        end else if (idx_q == LAST_PAY_IDX) begin
                            xmit_data_d = chk_q;
                        end else begin
                            xmit_data_d = pay_byte_c;
                            chk_d       = chk_q + pay_byte_c;
                            payload_d   = payload_q << 8;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            chk_q        <= '0;
            last_grant_q <= 1'b1;
            payload_q    <= '0;
            id_q         <= '0;
            xmit_data_q  <= '0;
            xmit_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            last_grant_q <= last_grant_d;
            payload_q    <= payload_d;
            id_q         <= id_d;
            xmit_data_q  <= xmit_data_d;
            xmit_q       <= xmit_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign xmitH      = xmit_q;
    assign xmit_dataH = xmit_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Testbench for uart_frame_sched: two instances (4-byte and 1-byte payload),
// each driving a behavioural UART model with random byte durations.
module tb_uart_frame_sched;

    localparam logic [7:0] ID0  = 8'h01;
    localparam logic [7:0] ID1  = 8'h02;
    localparam logic [7:0] SYNC = 8'hA5;

    logic sys_clk   = 1'b0;
    logic sys_rst_l = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        a_req0 = 1'b0, a_req1 = 1'b0;
    logic [31:0] a_data0 = '0, a_data1 = '0;
    logic        a_ack0, a_ack1, a_xmit, a_done, a_busy, a_fdone;
    logic [7:0]  a_xdata;

    logic        b_req0 = 1'b0, b_req1 = 1'b0;
    logic [7:0]  b_data0 = '0, b_data1 = '0;
    logic        b_ack0, b_ack1, b_xmit, b_done, b_busy, b_fdone;
    logic [7:0]  b_xdata;

    uart_frame_sched #(.PAYLOAD_BYTES(4)) dut_a (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
        .req0(a_req0), .data0(a_data0), .ack0(a_ack0),
        .req1(a_req1), .data1(a_data1), .ack1(a_ack1),
        .xmitH(a_xmit), .xmit_dataH(a_xdata), .xmit_doneH(a_done),
        .busy(a_busy), .frame_done(a_fdone)
    );

    uart_frame_sched #(.PAYLOAD_BYTES(1)) dut_b (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
        .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
        .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
        .xmitH(b_xmit), .xmit_dataH(b_xdata), .xmit_doneH(b_done),
        .busy(b_busy), .frame_done(b_fdone)
    );

    // UART model and event counters, one slot per instance.
    logic       xm [2];
    logic [7:0] xd [2];
    logic       ak0 [2];
    logic       ak1 [2];
    logic       fdn [2];
    logic       ubusy [2] = '{1'b0, 1'b0};
    logic       stall [2] = '{1'b0, 1'b0};
    logic [7:0] held [2];
    int         ucnt [2];
    int         strobes [2]    = '{0, 0};
    int         strobe_bad [2] = '{0, 0};
    int         unstable [2]   = '{0, 0};
    int         ack0_cyc [2]   = '{0, 0};
    int         ack1_cyc [2]   = '{0, 0};
    int         fd_cyc [2]     = '{0, 0};
    int         cap_cnt [2]    = '{0, 0};
    logic [7:0] cap_mem [2][256];

    assign xm[0]  = a_xmit;  assign xm[1]  = b_xmit;
    assign xd[0]  = a_xdata; assign xd[1]  = b_xdata;
    assign ak0[0] = a_ack0;  assign ak0[1] = b_ack0;
    assign ak1[0] = a_ack1;  assign ak1[1] = b_ack1;
    assign fdn[0] = a_fdone; assign fdn[1] = b_fdone;
    assign a_done = ~ubusy[0] & ~stall[0];
    assign b_done = ~ubusy[1] & ~stall[1];

    always @(posedge sys_clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ak0[1'(g)]) ack0_cyc[1'(g)] <= ack0_cyc[1'(g)] + 1;
            if (ak1[1'(g)]) ack1_cyc[1'(g)] <= ack1_cyc[1'(g)] + 1;
            if (fdn[1'(g)]) fd_cyc[1'(g)]   <= fd_cyc[1'(g)] + 1;
            if (xm[1'(g)]) begin
                strobes[1'(g)] <= strobes[1'(g)] + 1;
                if (ubusy[1'(g)] || stall[1'(g)]) strobe_bad[1'(g)] <= strobe_bad[1'(g)] + 1;
                cap_mem[1'(g)][8'(cap_cnt[1'(g)])] <= xd[1'(g)];
                cap_cnt[1'(g)] <= cap_cnt[1'(g)] + 1;
                held[1'(g)]    <= xd[1'(g)];
                ubusy[1'(g)]   <= 1'b1;
                ucnt[1'(g)]    <= int'($urandom_range(1, 5));
            end else if (ubusy[1'(g)]) begin
                if (xd[1'(g)] !== held[1'(g)]) unstable[1'(g)] <= unstable[1'(g)] + 1;
                if (ucnt[1'(g)] == 0) ubusy[1'(g)] <= 1'b0;
                else ucnt[1'(g)] <= ucnt[1'(g)] - 1;
            end
        end
    end

    int         compared = 0;
    int         failed   = 0;
    int         exp_last = 1;
    logic [7:0] exp_q [$];

    // Reference frame: sync, id, payload bytes MSB first, (id + payload) mod 256.
    task automatic push_frame(input logic [7:0] id, input logic [63:0] data, input int pb);
        int sum;
        logic [7:0] b;
        exp_q.push_back(SYNC);
        exp_q.push_back(id);
        sum = int'(id);
        for (int i = pb - 1; i >= 0; i--) begin
            b = 8'((data >> (8 * i)) & 64'hFF);
            exp_q.push_back(b);
            sum = sum + int'(b);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic wait_ack(input int g, output int which);
        which = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge sys_clk);
            if (ak0[1'(g)]) begin which = 0; break; end
            if (ak1[1'(g)]) begin which = 1; break; end
        end
    endtask

    task automatic wait_fd(input int g, input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (fd_cyc[1'(g)] >= target) begin ok = 1'b1; break; end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        compared++; if (a_ack0 !== 1'b0) begin failed++; $display("FAIL rst_ack0: got %b expected 0", a_ack0); end
        compared++; if (a_ack1 !== 1'b0) begin failed++; $display("FAIL rst_ack1: got %b expected 0", a_ack1); end
        compared++; if (a_xmit !== 1'b0) begin failed++; $display("FAIL rst_xmit: got %b expected 0", a_xmit); end
        compared++; if (a_busy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        compared++; if (a_fdone !== 1'b0) begin failed++; $display("FAIL rst_fdone: got %b expected 0", a_fdone); end
        compared++; if (a_xdata !== 8'h00) begin failed++; $display("FAIL rst_xdata: got %h expected 00", a_xdata); end
        compared++;
        if ({b_ack0, b_ack1, b_xmit, b_busy, b_fdone, b_xdata} !== 13'h0) begin
            failed++; $display("FAIL rst_inst_b: got %h expected 0", {b_ack0, b_ack1, b_xmit, b_busy, b_fdone, b_xdata});
        end
        sys_rst_l = 1'b1;
        exp_last  = 1;
        @(negedge sys_clk);
    endtask

    // Simultaneous requests right after reset: requester 0 first, then 1.
    task automatic test_tie();
        int w;
        int base;
        int f0;
        bit ok;
        logic [31:0] d0;
        for (int r = 0; r < 2; r++) begin
            exp_q.delete();
            base = cap_cnt[0];
            f0   = fd_cyc[0];
            d0   = (r == 0) ? 32'h11223344 : $urandom;
            a_data0 = d0;
            a_data1 = 32'hFFFFFFFF;
            a_req0  = 1'b1;
            a_req1  = 1'b1;
            wait_ack(0, w);
            if (w == 1) a_req1 = 1'b0; else a_req0 = 1'b0;
            compared++; if (w !== 0) begin failed++; $display("FAIL tie_first_r%0d: got %0d expected 0", r, w); end
            wait_ack(0, w);
            a_req0 = 1'b0;
            a_req1 = 1'b0;
            compared++; if (w !== 1) begin failed++; $display("FAIL tie_second_r%0d: got %0d expected 1", r, w); end
            exp_last = 1;
            push_frame(ID0, {32'h0, d0}, 4);
            push_frame(ID1, {32'h0, 32'hFFFFFFFF}, 4);
            wait_fd(0, f0 + 2, ok);
            compared++; if (ok !== 1'b1) begin failed++; $display("FAIL tie_timeout_r%0d: got %b expected 1", r, ok); end
            compared++; if (cap_cnt[0] - base !== exp_q.size()) begin failed++; $display("FAIL tie_len_r%0d: got %0d expected %0d", r, cap_cnt[0] - base, exp_q.size()); end
            foreach (exp_q[i]) begin
                compared++;
                if (cap_mem[0][8'(base + i)] !== exp_q[i]) begin
                    failed++; $display("FAIL tie_byte%0d_r%0d: got %h expected %h", i, r, cap_mem[0][8'(base + i)], exp_q[i]);
                end
            end
            compared++; if (cap_mem[0][8'(base + 13)] !== 8'hFE) begin failed++; $display("FAIL tie_chk1: got %h expected fe", cap_mem[0][8'(base + 13)]); end
        end
    endtask

    task automatic test_single(input bit change_after_ack);
        int w;
        int base;
        int s0;
        int a0;
        int a1;
        int f0;
        int u0;
        int sb;
        bit ok;
        exp_q.delete();
        base = cap_cnt[0]; s0 = strobes[0]; a0 = ack0_cyc[0]; a1 = ack1_cyc[0];
        f0 = fd_cyc[0]; u0 = unstable[0]; sb = strobe_bad[0];
        a_data0 = 32'h11223344;
        a_req0  = 1'b1;
        wait_ack(0, w);
        a_req0 = 1'b0;
        if (change_after_ack) a_data0 = 32'h0;
        compared++; if (w !== 0) begin failed++; $display("FAIL single_grant: got %0d expected 0", w); end
        exp_last = 0;
        push_frame(ID0, 64'h11223344, 4);
        wait_fd(0, f0 + 1, ok);
        @(negedge sys_clk);
        compared++; if (ok !== 1'b1) begin failed++; $display("FAIL single_timeout: got %b expected 1", ok); end
        compared++; if (strobes[0] - s0 !== 7) begin failed++; $display("FAIL single_strobes: got %0d expected 7", strobes[0] - s0); end
        compared++; if (ack0_cyc[0] - a0 !== 1) begin failed++; $display("FAIL single_ack0_cycles: got %0d expected 1", ack0_cyc[0] - a0); end
        compared++; if (ack1_cyc[0] - a1 !== 0) begin failed++; $display("FAIL single_ack1_cycles: got %0d expected 0", ack1_cyc[0] - a1); end
        compared++; if (fd_cyc[0] - f0 !== 1) begin failed++; $display("FAIL single_fdone_cycles: got %0d expected 1", fd_cyc[0] - f0); end
        compared++; if (a_busy !== 1'b0) begin failed++; $display("FAIL single_busy_after: got %b expected 0", a_busy); end
        compared++; if (unstable[0] - u0 !== 0) begin failed++; $display("FAIL single_data_stable: got %0d expected 0", unstable[0] - u0); end
        compared++; if (strobe_bad[0] - sb !== 0) begin failed++; $display("FAIL single_strobe_busy: got %0d expected 0", strobe_bad[0] - sb); end
        foreach (exp_q[i]) begin
            compared++;
            if (cap_mem[0][8'(base + i)] !== exp_q[i]) begin
                failed++; $display("FAIL single_byte%0d: got %h expected %h", i, cap_mem[0][8'(base + i)], exp_q[i]);
            end
        end
    endtask

    // Random request patterns; arbitration and framing from the reference model.
    task automatic test_random();
        int w;
        int exp_w;
        int base;
        int f0;
        int nfr;
        int mask;
        int sb;
        bit ok;
        logic [31:0] d0;
        logic [31:0] d1;
        sb = strobe_bad[0];
        for (int it = 0; it < 12; it++) begin
            exp_q.delete();
            base = cap_cnt[0];
            f0   = fd_cyc[0];
            mask = int'($urandom_range(1, 3));
            d0 = $urandom;
            d1 = $urandom;
            a_data0 = d0;
            a_data1 = d1;
            a_req0  = mask[0];
            a_req1  = mask[1];
            if (mask == 3) exp_w = (exp_last == 1) ? 0 : 1;
            else           exp_w = (mask == 2) ? 1 : 0;
            wait_ack(0, w);
            if (w == 1) a_req1 = 1'b0;
            else if (w == 0) a_req0 = 1'b0;
            else begin a_req0 = 1'b0; a_req1 = 1'b0; end
            if ($urandom_range(0, 1) == 1) begin
                if (w == 1) a_data1 = $urandom; else a_data0 = $urandom;
            end
            compared++; if (w !== exp_w) begin failed++; $display("FAIL rand_grant_it%0d: got %0d expected %0d", it, w, exp_w); end
            push_frame(exp_w == 1 ? ID1 : ID0, {32'h0, exp_w == 1 ? d1 : d0}, 4);
            exp_last = exp_w;
            nfr = 1;
            if (mask == 3) begin
                exp_w = 1 - exp_w;
                wait_ack(0, w);
                a_req0 = 1'b0;
                a_req1 = 1'b0;
                compared++; if (w !== exp_w) begin failed++; $display("FAIL rand_grant2_it%0d: got %0d expected %0d", it, w, exp_w); end
                push_frame(exp_w == 1 ? ID1 : ID0, {32'h0, exp_w == 1 ? d1 : d0}, 4);
                exp_last = exp_w;
                nfr = 2;
            end
            wait_fd(0, f0 + nfr, ok);
            compared++; if (ok !== 1'b1) begin failed++; $display("FAIL rand_timeout_it%0d: got %b expected 1", it, ok); end
            foreach (exp_q[i]) begin
                compared++;
                if (cap_mem[0][8'(base + i)] !== exp_q[i]) begin
                    failed++; $display("FAIL rand_it%0d_byte%0d: got %h expected %h", it, i, cap_mem[0][8'(base + i)], exp_q[i]);
                end
            end
        end
        compared++; if (strobe_bad[0] - sb !== 0) begin failed++; $display("FAIL rand_strobe_busy: got %0d expected 0", strobe_bad[0] - sb); end
    endtask

    // UART held not-done: no grant while idle, no strobe while stalled mid-frame.
    task automatic test_flow();
        int w;
        int base;
        int s0;
        int a0;
        int f0;
        int sb;
        int s_hold;
        bit ok;
        logic [31:0] d0;
        exp_q.delete();
        base = cap_cnt[0]; s0 = strobes[0]; a0 = ack0_cyc[0]; f0 = fd_cyc[0]; sb = strobe_bad[0];
        d0 = $urandom;
        stall[0] = 1'b1;
        a_data0  = d0;
        a_req0   = 1'b1;
        repeat (20) @(negedge sys_clk);
        compared++; if (ack0_cyc[0] - a0 !== 0) begin failed++; $display("FAIL flow_ack_stalled: got %0d expected 0", ack0_cyc[0] - a0); end
        compared++; if (strobes[0] - s0 !== 0) begin failed++; $display("FAIL flow_strobe_stalled: got %0d expected 0", strobes[0] - s0); end
        compared++; if (a_busy !== 1'b0) begin failed++; $display("FAIL flow_busy_stalled: got %b expected 0", a_busy); end
        stall[0] = 1'b0;
        wait_ack(0, w);
        a_req0 = 1'b0;
        compared++; if (w !== 0) begin failed++; $display("FAIL flow_grant: got %0d expected 0", w); end
        exp_last = 0;
        push_frame(ID0, {32'h0, d0}, 4);
        for (int i = 0; i < 500 && (strobes[0] - s0) < 3; i++) @(negedge sys_clk);
        stall[0] = 1'b1;
        s_hold = strobes[0];
        repeat (30) @(negedge sys_clk);
        compared++; if (strobes[0] !== s_hold) begin failed++; $display("FAIL flow_midframe_strobe: got %0d expected %0d", strobes[0], s_hold); end
        stall[0] = 1'b0;
        wait_fd(0, f0 + 1, ok);
        compared++; if (ok !== 1'b1) begin failed++; $display("FAIL flow_timeout: got %b expected 1", ok); end
        compared++; if (strobe_bad[0] - sb !== 0) begin failed++; $display("FAIL flow_strobe_busy: got %0d expected 0", strobe_bad[0] - sb); end
        foreach (exp_q[i]) begin
            compared++;
            if (cap_mem[0][8'(base + i)] !== exp_q[i]) begin
                failed++; $display("FAIL flow_byte%0d: got %h expected %h", i, cap_mem[0][8'(base + i)], exp_q[i]);
            end
        end
    endtask

    // Reset during the 4th byte aborts the frame; a new request starts over.
    task automatic test_reset_midframe();
        int w;
        int base;
        int s0;
        int a0;
        int f0;
        bit ok;
        s0 = strobes[0];
        a_data0 = 32'h11223344;
        a_req0  = 1'b1;
        wait_ack(0, w);
        a_req0 = 1'b0;
        for (int i = 0; i < 500 && (strobes[0] - s0) < 4; i++) @(negedge sys_clk);
        compared++; if (strobes[0] - s0 !== 4) begin failed++; $display("FAIL rstmid_reach4: got %0d expected 4", strobes[0] - s0); end
        sys_rst_l = 1'b0;
        @(negedge sys_clk);
        compared++;
        if ({a_ack0, a_ack1, a_xmit, a_busy, a_fdone, a_xdata} !== 13'h0) begin
            failed++; $display("FAIL rstmid_outputs: got %h expected 0", {a_ack0, a_ack1, a_xmit, a_busy, a_fdone, a_xdata});
        end
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        exp_last  = 1;
        s0 = strobes[0]; a0 = ack0_cyc[0] + ack1_cyc[0];
        repeat (30) @(negedge sys_clk);
        compared++; if (strobes[0] !== s0) begin failed++; $display("FAIL rstmid_no_strobe: got %0d expected %0d", strobes[0], s0); end
        compared++; if (ack0_cyc[0] + ack1_cyc[0] !== a0) begin failed++; $display("FAIL rstmid_no_ack: got %0d expected %0d", ack0_cyc[0] + ack1_cyc[0], a0); end
        compared++; if (a_busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy: got %b expected 0", a_busy); end
        exp_q.delete();
        base = cap_cnt[0]; f0 = fd_cyc[0];
        a_req0 = 1'b1;
        wait_ack(0, w);
        a_req0 = 1'b0;
        compared++; if (w !== 0) begin failed++; $display("FAIL rstmid_regrant: got %0d expected 0", w); end
        exp_last = 0;
        push_frame(ID0, 64'h11223344, 4);
        wait_fd(0, f0 + 1, ok);
        compared++; if (ok !== 1'b1) begin failed++; $display("FAIL rstmid_timeout: got %b expected 1", ok); end
        foreach (exp_q[i]) begin
            compared++;
            if (cap_mem[0][8'(base + i)] !== exp_q[i]) begin
                failed++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, cap_mem[0][8'(base + i)], exp_q[i]);
            end
        end
    endtask

    // One-byte payload instance.
    task automatic test_pb1();
        int w;
        int base;
        int s0;
        int f0;
        bit ok;
        exp_q.delete();
        base = cap_cnt[1]; s0 = strobes[1]; f0 = fd_cyc[1];
        b_data0 = 8'h7F;
        b_req0  = 1'b1;
        wait_ack(1, w);
        b_req0 = 1'b0;
        compared++; if (w !== 0) begin failed++; $display("FAIL pb1_grant: got %0d expected 0", w); end
        push_frame(ID0, 64'h7F, 1);
        wait_fd(1, f0 + 1, ok);
        @(negedge sys_clk);
        compared++; if (ok !== 1'b1) begin failed++; $display("FAIL pb1_timeout: got %b expected 1", ok); end
        compared++; if (strobes[1] - s0 !== 4) begin failed++; $display("FAIL pb1_strobes: got %0d expected 4", strobes[1] - s0); end
        compared++; if (cap_mem[1][8'(base + 3)] !== 8'h80) begin failed++; $display("FAIL pb1_chk: got %h expected 80", cap_mem[1][8'(base + 3)]); end
        foreach (exp_q[i]) begin
            compared++;
            if (cap_mem[1][8'(base + i)] !== exp_q[i]) begin
                failed++; $display("FAIL pb1_byte%0d: got %h expected %h", i, cap_mem[1][8'(base + i)], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single(1'b0);
        test_single(1'b1);
        test_random();
        test_flow();
        test_reset_midframe();
        test_pb1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
